// File: rtl/cv32e40p_bb_monitor_if.sv
// Instruction-in / block-record-out bundle for the basic-block monitor.
interface cv32e40p_bb_monitor_if #(
   parameter int MAX_BB_LEN = 16
);
   localparam int LEN_W = $clog2(MAX_BB_LEN + 2);

   logic             instr_valid_i;
   logic             instr_ready_o;
   logic [31:0]      instr_i;
   logic [31:0]      instr_addr_i;
   logic             rec_valid_o;
   logic             rec_ready_i;
   logic [31:0]      rec_addr_o;
   logic [LEN_W-1:0] rec_len_o;
   logic [31:0]      rec_sig_o;
   logic [1:0]       rec_term_o;

   modport master (
      output instr_valid_i, instr_i, instr_addr_i, rec_ready_i,
      input  instr_ready_o, rec_valid_o, rec_addr_o, rec_len_o,
      input  rec_sig_o, rec_term_o
   );

   modport slave (
      input  instr_valid_i, instr_i, instr_addr_i, rec_ready_i,
      output instr_ready_o, rec_valid_o, rec_addr_o, rec_len_o,
      output rec_sig_o, rec_term_o
   );
endinterface

// File: rtl/cv32e40p_bb_monitor.sv
// Splits the instruction stream into basic blocks and queues
// {start, length, rotate-XOR signature, terminator} records.
module cv32e40p_bb_monitor #(
   parameter int MAX_BB_LEN = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic flush_i,
   cv32e40p_bb_monitor_if.slave bus,
   output logic [$clog2(MAX_BB_LEN+2)-1:0] cur_len_o,
   output logic overflow_o
);
   localparam int LEN_W = $clog2(MAX_BB_LEN + 2);
   localparam int PW    = $clog2(FIFO_DEPTH);
   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_BB_LEN + 1);

   typedef struct packed {
      logic [31:0]      addr;
      logic [LEN_W-1:0] len;
      logic [31:0]      sig;
      logic [1:0]       term;
   } rec_t;

   logic [LEN_W-1:0] len;
   logic [31:0]      sig;
   logic [31:0]      start_addr;
   logic             ovf;
   logic [PW:0]      wptr;
   logic [PW:0]      rptr;
   rec_t             mem [FIFO_DEPTH];

   logic             full;
   logic             empty;
   logic             ready;
   logic             beat;
   logic             push;
   logic             pop;
   logic             is_disc;
   logic             ovf_hit;
   logic [31:0]      d;
   logic [31:0]      sig_n;
   logic [LEN_W-1:0] len_n;
   logic [31:0]      start_n;
   logic [1:0]       term;
   logic [31:0]      in;
   rec_t             rec_in;
   rec_t             head;

   assign in    = bus.instr_i;
   assign empty = (wptr == rptr);
   assign full  = (wptr[PW] != rptr[PW]) &&
                  (wptr[PW-1:0] == rptr[PW-1:0]);
   assign ready = !rst && !full && !flush_i;
   assign bus.instr_ready_o = ready;

   // An all-zero word is a bubble from upstream and is swallowed.
   assign beat = bus.instr_valid_i && ready && (in != 32'h0);

   always_comb begin
      is_disc = 1'b0;
      if (in[1:0] == 2'b01)
         is_disc = (in[15:13] == 3'b001) || (in[15:13] == 3'b101) ||
                   (in[15:13] == 3'b110) || (in[15:13] == 3'b111);
      else if (in[1:0] == 2'b10)
         is_disc = (in[15:13] == 3'b100) && (in[6:2] == 5'd0) &&
                   (in[11:7] != 5'd0);
      else if (in[1:0] == 2'b11)
         is_disc = (in[6:0] == 7'b1100011) || (in[6:0] == 7'b1101111) ||
                   ((in[6:0] == 7'b1100111) && (in[14:12] == 3'b000));
   end

   assign d       = (in[1:0] != 2'b11) ? {16'h0, in[15:0]} : in;
   assign sig_n   = {sig[30:0], sig[31]} ^ d;
   assign len_n   = len + LEN_W'(1);
   assign start_n = (len == '0) ? bus.instr_addr_i : start_addr;
   assign ovf_hit = !is_disc && (len_n == LEN_MAX);
   assign push    = beat && (is_disc || ovf_hit);
   assign pop     = !empty && bus.rec_ready_i;

   always_comb begin
      term = 2'd2;
      if (is_disc)
         term = (in == 32'h0000_006f) ? 2'd1 : 2'd0;
   end

   assign rec_in = '{addr: start_n, len: len_n, sig: sig_n, term: term};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len        <= '0;
         sig        <= '0;
         start_addr <= '0;
         ovf        <= 1'b0;
         wptr       <= '0;
         rptr       <= '0;
      end else begin
         if (flush_i) begin
            len <= '0;
            sig <= '0;
         end else if (beat) begin
            start_addr <= start_n;
            if (push) begin
               len <= '0;
               sig <= '0;
            end else begin
               len <= len_n;
               sig <= sig_n;
            end
         end
         if (beat && ovf_hit)
            ovf <= 1'b1;
         if (push)
            wptr <= wptr + (PW+1)'(1);
         if (pop)
            rptr <= rptr + (PW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wptr[PW-1:0]] <= rec_in;
   end

   assign head = mem[rptr[PW-1:0]];

   assign bus.rec_valid_o = !empty;
   assign bus.rec_addr_o  = empty ? '0 : head.addr;
   assign bus.rec_len_o   = empty ? '0 : head.len;
   assign bus.rec_sig_o   = empty ? '0 : head.sig;
   assign bus.rec_term_o  = empty ? '0 : head.term;

   assign cur_len_o  = len;
   assign overflow_o = ovf;
endmodule
